// File: rtl/io_cpx_reqdata_pipe.sv
`default_nettype none
// ============================================================================
// Module   : io_cpx_reqdata_pipe
// Purpose  : Retiming pipeline for the IO-to-CPX request/data path with
//            per-destination outstanding-packet credit tracking and sticky
//            overflow/underflow error flags.
// Ports    :
//   rclk                 in   clock, rising edge
//   arst                 in   asynchronous active-high reset
//   io_cpx_req_cq        in   [NREQ] per-destination request (one cycle ahead of data)
//   io_cpx_data_ca       in   [DW]   packet data
//   cpx_io_grant_cx      in   [NREQ] per-destination dequeue grant from CPX
//   err_clr              in   clears sticky error flags
//   io_cpx_req_cq2       out  [NREQ] request delayed STAGES cycles
//   io_cpx_data_ca2      out  [DW]   data delayed STAGES cycles
//   io_cpx_credit_avail  out  [NREQ] destination has room (outstanding < QDEPTH)
//   io_cpx_err_ovf       out  [NREQ] sticky: request to a full destination
//   io_cpx_err_unf       out  [NREQ] sticky: grant with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module io_cpx_reqdata_pipe #(
    parameter int DW     = 145,
    parameter int NREQ   = 8,
    parameter int STAGES = 2,   // legal 1..4
    parameter int QDEPTH = 2,   // legal 1..7
    parameter int CW     = 3    // 2**CW must exceed QDEPTH
) (
    input  logic            rclk,
    input  logic            arst,
    input  logic [NREQ-1:0] io_cpx_req_cq,
    input  logic [DW-1:0]   io_cpx_data_ca,
    input  logic [NREQ-1:0] cpx_io_grant_cx,
    input  logic            err_clr,
    output logic [NREQ-1:0] io_cpx_req_cq2,
    output logic [DW-1:0]   io_cpx_data_ca2,
    output logic [NREQ-1:0] io_cpx_credit_avail,
    output logic [NREQ-1:0] io_cpx_err_ovf,
    output logic [NREQ-1:0] io_cpx_err_unf
);

    localparam logic [CW-1:0] c_qdepth = CW'(QDEPTH);
    localparam logic [CW-1:0] c_one    = CW'(1);

    // ------------------------------------------------------------------------
    // Retiming pipeline. Request and data travel through identical-depth
    // shift registers, so the one-cycle request-to-data offset seen at the
    // input is reproduced exactly at the output. No enable, no gating.
    // ------------------------------------------------------------------------
    logic [NREQ-1:0] r_req_pipe  [STAGES];
    logic [DW-1:0]   r_data_pipe [STAGES];

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_req_pipe[s]  <= '0;
                r_data_pipe[s] <= '0;
            end
        end else begin
            r_req_pipe[0]  <= io_cpx_req_cq;
            r_data_pipe[0] <= io_cpx_data_ca;
            for (int s = 1; s < STAGES; s++) begin
                r_req_pipe[s]  <= r_req_pipe[s-1];
                r_data_pipe[s] <= r_data_pipe[s-1];
            end
        end
    end

    assign io_cpx_req_cq2  = r_req_pipe[STAGES-1];
    assign io_cpx_data_ca2 = r_data_pipe[STAGES-1];

    // ------------------------------------------------------------------------
    // Per-destination outstanding counters. They are driven from the raw
    // inputs rather than the delayed outputs so that credit already accounts
    // for packets still travelling through the retiming stages.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NREQ; i++) begin : g_dest
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;
        logic          w_ovf_evt;
        logic          w_unf_evt;
        logic          r_credit;
        logic          r_ovf;
        logic          r_unf;

        always_comb begin
            w_cnt_nxt = r_cnt;
            w_ovf_evt = 1'b0;
            w_unf_evt = 1'b0;
            case ({io_cpx_req_cq[i], cpx_io_grant_cx[i]})
                2'b10: begin
                    // Saturate at QDEPTH instead of wrapping.
                    if (r_cnt < c_qdepth) w_cnt_nxt = r_cnt + c_one;
                    else                  w_ovf_evt = 1'b1;
                end
                2'b01: begin
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - c_one;
                    else             w_unf_evt = 1'b1;
                end
                // Simultaneous request and grant cancel out, even when the
                // counter sits at an extreme; idle holds.
                default: ;
            endcase
        end

        always_ff @(posedge rclk or posedge arst) begin
            if (arst) begin
                r_cnt    <= '0;
                r_credit <= 1'b1;
                r_ovf    <= 1'b0;
                r_unf    <= 1'b0;
            end else begin
                r_cnt    <= w_cnt_nxt;
                // Registered look-ahead on the next count keeps credit
                // accurate the cycle after the update without a comb path.
                r_credit <= (w_cnt_nxt < c_qdepth);
                // Clear wins over a same-cycle error event; that event is lost.
                if (err_clr) begin
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                end else begin
                    r_ovf <= r_ovf | w_ovf_evt;
                    r_unf <= r_unf | w_unf_evt;
                end
            end
        end

        assign io_cpx_credit_avail[i] = r_credit;
        assign io_cpx_err_ovf[i]      = r_ovf;
        assign io_cpx_err_unf[i]      = r_unf;
    end

endmodule
`default_nettype wire

// File: tb/tb_io_cpx_reqdata_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_cpx_reqdata_pipe
// Purpose  : Directed self-checking bench for io_cpx_reqdata_pipe. A default
//            instance (STAGES=2, NREQ=8, QDEPTH=2) takes directed vectors;
//            two NREQ=4 instances (STAGES=1 and STAGES=4) take a shared
//            pseudo-random stream checked against a delay history and a
//            counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_cpx_reqdata_pipe;

    localparam int DW = 145;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- default instance ----------------
    logic [7:0]    req = '0, grant = '0;
    logic [DW-1:0] data = '0;
    logic          clr = 1'b0;
    logic [7:0]    req2, credit, ovf, unf;
    logic [DW-1:0] data2;

    io_cpx_reqdata_pipe u_dut (
        .rclk(clk), .arst(rst),
        .io_cpx_req_cq(req), .io_cpx_data_ca(data),
        .cpx_io_grant_cx(grant), .err_clr(clr),
        .io_cpx_req_cq2(req2), .io_cpx_data_ca2(data2),
        .io_cpx_credit_avail(credit),
        .io_cpx_err_ovf(ovf), .io_cpx_err_unf(unf)
    );

    // ---------------- sweep instances ----------------
    logic [3:0]    sreq = '0, sgrant = '0;
    logic [DW-1:0] sdata = '0;
    logic          sclr = 1'b0;
    logic [3:0]    s1_req2, s1_credit, s1_ovf, s1_unf;
    logic [3:0]    s4_req2, s4_credit, s4_ovf, s4_unf;
    logic [DW-1:0] s1_data2, s4_data2;

    io_cpx_reqdata_pipe #(.DW(DW), .NREQ(4), .STAGES(1), .QDEPTH(2), .CW(3)) u_s1 (
        .rclk(clk), .arst(rst),
        .io_cpx_req_cq(sreq), .io_cpx_data_ca(sdata),
        .cpx_io_grant_cx(sgrant), .err_clr(sclr),
        .io_cpx_req_cq2(s1_req2), .io_cpx_data_ca2(s1_data2),
        .io_cpx_credit_avail(s1_credit),
        .io_cpx_err_ovf(s1_ovf), .io_cpx_err_unf(s1_unf)
    );

    io_cpx_reqdata_pipe #(.DW(DW), .NREQ(4), .STAGES(4), .QDEPTH(3), .CW(2)) u_s4 (
        .rclk(clk), .arst(rst),
        .io_cpx_req_cq(sreq), .io_cpx_data_ca(sdata),
        .cpx_io_grant_cx(sgrant), .err_clr(sclr),
        .io_cpx_req_cq2(s4_req2), .io_cpx_data_ca2(s4_data2),
        .io_cpx_credit_avail(s4_credit),
        .io_cpx_err_ovf(s4_ovf), .io_cpx_err_unf(s4_unf)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of control inputs on the default instance.
    task automatic cyc(input logic [7:0] r, input logic [7:0] g, input logic c);
        req = r; grant = g; clr = c;
        tick();
        req = '0; grant = '0; clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Sweep history and models
    logic [3:0]    hist_req  [300];
    logic [DW-1:0] hist_data [300];
    int            mcnt [2][4];
    int            mq   [2];
    logic [3:0]    mcred [2], movf [2], munf [2];
    logic [3:0]    exp_req;
    logic [DW-1:0] exp_data;

    initial begin
        // ---------- 1. reset / latency ----------
        tick();
        check("rst_req2",   {248'd0, req2},   256'h0);
        check("rst_data2",  {111'd0, data2},  256'h0);
        check("rst_credit", {248'd0, credit}, 256'hFF);
        check("rst_ovf",    {248'd0, ovf},    256'h0);
        check("rst_unf",    {248'd0, unf},    256'h0);

        rst = 1'b0;
        req = 8'h04; data = 145'h5555;
        tick();
        tick();
        check("pre_req2",   {248'd0, req2},   256'h04);
        check("pre_credit", {248'd0, credit}, 256'hFB);
        #2 rst = 1'b1;          // asynchronous assertion mid-cycle
        #1;
        check("async_req2",   {248'd0, req2},   256'h0);
        check("async_data2",  {111'd0, data2},  256'h0);
        check("async_credit", {248'd0, credit}, 256'hFF);
        req = '0; data = '0;
        tick();
        check("hold_req2", {248'd0, req2}, 256'h0);
        rst = 1'b0;
        req = 8'h01;                           // c0
        tick();
        check("c0_req2",  {248'd0, req2},  256'h0);
        check("c0_data2", {111'd0, data2}, 256'h0);
        req = 8'h00; data = 145'h1ABC;         // c1
        tick();
        check("c2_req2",  {248'd0, req2},  256'h01);
        check("c2_data2", {111'd0, data2}, 256'h0);
        data = '0;                             // c2
        tick();
        check("c3_req2",  {248'd0, req2},  256'h0);
        check("c3_data2", {111'd0, data2}, 256'h1ABC);
        tick();
        check("c4_data2", {111'd0, data2}, 256'h0);

        // ---------- 2. credit exhaust ----------
        do_reset();
        cyc(8'h08, 8'h00, 1'b0);
        check("cr_after_c0", {248'd0, credit}, 256'hFF);
        cyc(8'h08, 8'h00, 1'b0);
        check("cr_after_c1", {248'd0, credit}, 256'hF7);
        cyc(8'h00, 8'h00, 1'b0);
        check("cr_after_c2", {248'd0, credit}, 256'hF7);
        cyc(8'h00, 8'h08, 1'b0);
        check("cr_after_c3", {248'd0, credit}, 256'hFF);
        check("cr_no_err",   {240'd0, ovf, unf}, 256'h0);

        // ---------- 3. overflow / clear priority ----------
        do_reset();
        cyc(8'h20, 8'h00, 1'b0);
        cyc(8'h20, 8'h00, 1'b0);
        check("ov_full", {248'd0, ovf}, 256'h0);
        cyc(8'h20, 8'h00, 1'b0);
        check("ov_set",    {248'd0, ovf},    256'h20);
        check("ov_credit", {248'd0, credit}, 256'hDF);
        cyc(8'h00, 8'h00, 1'b1);
        check("ov_clr", {248'd0, ovf}, 256'h0);
        cyc(8'h20, 8'h00, 1'b1);               // clear beats simultaneous event
        check("ov_clr_prio", {248'd0, ovf}, 256'h0);
        cyc(8'h00, 8'h00, 1'b0);
        check("ov_event_lost", {248'd0, ovf}, 256'h0);
        cyc(8'h00, 8'h20, 1'b0);               // one grant frees a slot: count held at 2
        check("ov_one_grant", {248'd0, credit}, 256'hFF);
        cyc(8'h00, 8'h20, 1'b0);
        check("ov_drain_no_unf", {248'd0, unf}, 256'h0);
        cyc(8'h00, 8'h20, 1'b0);
        check("ov_then_unf", {248'd0, unf}, 256'h20);

        // ---------- 4. underflow / simultaneous ----------
        do_reset();
        cyc(8'h01, 8'h01, 1'b0);
        check("sim_no_err", {240'd0, ovf, unf}, 256'h0);
        check("sim_credit", {248'd0, credit},   256'hFF);
        cyc(8'h00, 8'h01, 1'b0);
        check("unf_set",  {248'd0, unf}, 256'h01);
        cyc(8'h01, 8'h00, 1'b0);
        check("unf_cnt1", {248'd0, credit}, 256'hFF);
        cyc(8'h01, 8'h00, 1'b0);
        check("unf_cnt2", {248'd0, credit}, 256'hFE);
        check("unf_no_ovf", {248'd0, ovf}, 256'h0);
        cyc(8'h01, 8'h01, 1'b0);               // simultaneous at full: no error
        check("sim_full_no_ovf", {248'd0, ovf},    256'h0);
        check("sim_full_credit", {248'd0, credit}, 256'hFE);

        // ---------- 5. broadcast ----------
        do_reset();
        cyc(8'hFF, 8'h00, 1'b0);
        check("bc_first",  {248'd0, credit}, 256'hFF);
        cyc(8'hFF, 8'h00, 1'b0);
        check("bc_second", {248'd0, credit}, 256'h00);
        check("bc_no_ovf", {248'd0, ovf},    256'h0);

        // ---------- 6. STAGES=1 / STAGES=4 sweep ----------
        do_reset();
        mq[0] = 2;
        mq[1] = 3;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) mcnt[k][i] = 0;
            mcred[k] = 4'hF; movf[k] = '0; munf[k] = '0;
        end
        for (int n = 0; n < 300; n++) begin
            sreq   = 4'($urandom_range(0, 15));
            sgrant = 4'($urandom_range(0, 15));
            sclr   = ($urandom_range(0, 15) == 0);
            sdata  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            hist_req[n]  = sreq;
            hist_data[n] = sdata;
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) begin
                    logic eo, eu;
                    eo = 1'b0; eu = 1'b0;
                    if (sreq[i] && !sgrant[i]) begin
                        if (mcnt[k][i] < mq[k]) mcnt[k][i]++;
                        else eo = 1'b1;
                    end else if (!sreq[i] && sgrant[i]) begin
                        if (mcnt[k][i] > 0) mcnt[k][i]--;
                        else eu = 1'b1;
                    end
                    if (sclr) begin
                        movf[k][i] = 1'b0;
                        munf[k][i] = 1'b0;
                    end else begin
                        movf[k][i] = movf[k][i] | eo;
                        munf[k][i] = munf[k][i] | eu;
                    end
                    mcred[k][i] = (mcnt[k][i] < mq[k]);
                end
            end
            tick();
            check("s1_req2",   {252'd0, s1_req2},   {252'd0, hist_req[n]});
            check("s1_data2",  {111'd0, s1_data2},  {111'd0, hist_data[n]});
            check("s1_credit", {252'd0, s1_credit}, {252'd0, mcred[0]});
            check("s1_err",    {248'd0, s1_ovf, s1_unf}, {248'd0, movf[0], munf[0]});
            exp_req  = (n >= 3) ? hist_req[n-3]  : 4'h0;
            exp_data = (n >= 3) ? hist_data[n-3] : '0;
            check("s4_req2",   {252'd0, s4_req2},   {252'd0, exp_req});
            check("s4_data2",  {111'd0, s4_data2},  {111'd0, exp_data});
            check("s4_credit", {252'd0, s4_credit}, {252'd0, mcred[1]});
            check("s4_err",    {248'd0, s4_ovf, s4_unf}, {248'd0, movf[1], munf[1]});
        end
        sreq = '0; sgrant = '0; sclr = 1'b0; sdata = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_cpx_reqdata_pipe.md
Name: io_cpx_reqdata_pipe

Overview:
Parametrised retiming pipeline for the IO-to-CPX request/data path, with per-destination credit tracking.
- Delays the per-destination request vector and the CPX packet by a configurable number of register stages. The one-cycle request-to-data offset is preserved.
- Tracks outstanding packets per destination queue against CPX grants and exposes a registered credit-available vector to the IO-side arbiter.
- Flags sticky overflow/underflow errors.
- Sits between the IO bridge packet source and the CPX crossbar inputs.

Parameters:
- DW, 145 (`CPX_WIDTH): CPX packet width.
- NREQ, 8: number of destination channels (request vector width).
- STAGES, 2: pipeline depth; legal 1..4.
- QDEPTH, 2: CPX queue entries per destination; legal 1..7.
- CW, 3: outstanding-counter width; must satisfy 2^CW > QDEPTH.

Ports:
- rclk  in  1  clock; all flops rising-edge.
- arst  in  1  reset; asynchronous, active-high.
- io_cpx_req_cq  in  NREQ  per-destination request, one cycle ahead of data.
- io_cpx_data_ca  in  DW  packet data.
- cpx_io_grant_cx  in  NREQ  per-destination dequeue grant from CPX.
- err_clr  in  1  clears sticky error bits.
- io_cpx_req_cq2  out  NREQ  request delayed STAGES cycles.
- io_cpx_data_ca2  out  DW  data delayed STAGES cycles.
- io_cpx_credit_avail  out  NREQ  bit i=1 when destination i has outstanding < QDEPTH.
- io_cpx_err_ovf  out  NREQ  sticky: request to a full destination.
- io_cpx_err_unf  out  NREQ  sticky: grant with nothing outstanding.

Behaviour:
- Reset (arst=1, asynchronous assert) forces the following; release is synchronous to rclk.
  - All pipeline stage registers to 0, so req_cq2=0 and data_ca2=0.
  - Counters cnt[i]=0.
  - credit_avail = all ones.
  - err_ovf=0, err_unf=0.
- Reset mid-operation: in-flight requests/data are discarded. No partial packet may appear after release; outputs stay 0 until new input propagates.
- Pipeline:
  - req_cq2 at cycle t+STAGES equals req_cq at cycle t; same for data.
  - Pure shift: no enable, no stall, no gating of data by request.
  - A request at t followed by data at t+1 emerges as req at t+STAGES, data at t+STAGES+1.
- Counter per destination i, updated each rclk edge from the inputs (not the pipeline outputs) so credit reflects in-flight packets:
  - req[i]=1, grant[i]=0: if cnt<QDEPTH then cnt+1; else cnt holds at QDEPTH and err_ovf[i] sets.
  - req[i]=0, grant[i]=1: if cnt>0 then cnt-1; else cnt holds at 0 and err_unf[i] sets.
  - req[i]=1, grant[i]=1: cnt unchanged, no error (including at cnt=0 and cnt=QDEPTH).
  - Neither asserted: hold.
- Multiple request bits asserted in one cycle (broadcast) are legal; each destination updates independently.
- credit_avail[i] is registered and equals (next cnt[i] < QDEPTH), so it is valid the cycle after the update, with no combinational input-to-output path.
- Errors:
  - Sticky until err_clr=1 for one cycle.
  - err_clr takes priority over a new error event in the same cycle; that event is lost, which is documented and accepted.
  - Counters never wrap.
- No combinational paths from any input to any output.

Test Plan:
1. Reset/latency: STAGES=2. Assert arst mid-stream with req=8'h04 in flight, then release and drive req=8'h01 at c0 and data=145'h1ABC at c1. Required: outputs 0 throughout reset; req_cq2=8'h01 at c2, data_ca2=145'h1ABC at c3, zeros elsewhere.
2. Credit exhaust: QDEPTH=2, req[3] at c0 and c1, no grants. Required: credit_avail[3]=1 after c0, 0 after c1. Grant[3] at c3 restores credit_avail[3]=1 after c3.
3. Overflow: cnt[5]=2, req[5] with grant[5]=0. Required: err_ovf[5]=1 next cycle, cnt stays 2. err_clr next cycle gives err_ovf=0.
4. Underflow/simultaneous: cnt[0]=0, req[0]=1 with grant[0]=1. Required: no error, cnt stays 0. Then grant[0] alone gives err_unf[0]=1, cnt stays 0.
5. Broadcast: req=8'hFF for one cycle from all-zero counts. Required: all cnt=1, credit_avail=8'hFF. Repeat once more: credit_avail=8'h00.
6. Parameter sweep: STAGES=1 and 4, NREQ=4, random req/data streams with grants. Required: scoreboard match on delay STAGES, and the counter model matches credit_avail every cycle.
